// File: rtl/multi_cycle_control_if.sv
// Memory-side handshake of the multi-cycle sequencer: request strobes and address select out, ready back.
// The controller takes the master modport; the memory model or bus bridge takes the slave modport.
interface multi_cycle_control_if;
  logic Mem_Read_o;
  logic Mem_Write_o;
  logic Adr_Src_o;
  logic Mem_Ready_i;

  modport master (
    output Mem_Read_o,
    output Mem_Write_o,
    output Adr_Src_o,
    input  Mem_Ready_i
  );

  modport slave (
    input  Mem_Read_o,
    input  Mem_Write_o,
    input  Adr_Src_o,
    output Mem_Ready_i
  );
endinterface

// File: rtl/multi_cycle_control.sv
// Multi-cycle RISC-V sequencer: R/I/LUI/store 4 cycles, load 5, BEQ 3, +1 per memory wait cycle, wait timeout -> bus error.
// Memory waits stall on Mem_Ready_i; optional retired counter Retired_o is built when MC_RETIRE_COUNT_EN is defined.
module multi_cycle_control #(
  parameter int TIMEOUT_CYCLES = 16
`ifdef MC_RETIRE_COUNT_EN
  ,
  parameter int COUNT_W = 32
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            Op_i,
  multi_cycle_control_if.master mem_bus,
  output logic                  PC_Write_o,
  output logic                  IR_Write_o,
  output logic                  Reg_Write_o,
  output logic                  Branch_o,
  output logic [1:0]            ALU_Src_A_o,
  output logic [1:0]            ALU_Src_B_o,
  output logic [1:0]            Result_Src_o,
  output logic [2:0]            ALU_Op_o,
  output logic [3:0]            State_o,
  output logic                  Illegal_Op_o,
  output logic                  Bus_Error_o
`ifdef MC_RETIRE_COUNT_EN
  ,
  output logic [COUNT_W-1:0]    Retired_o
`endif
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_EXEC_LUI  = 4'd8,
    S_ALU_WB    = 4'd9,
    S_BRANCH    = 4'd10
  } state_e;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  // The counter only has to hold TIMEOUT_CYCLES-1: the limit is detected on the last not-ready cycle.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_e           state_q, state_d;
  logic [6:0]       op_q, op_d;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             illegal_q, illegal_d;
  logic             bus_err_q, bus_err_d;
  logic             mem_ready;
  logic             in_wait;
  logic             tmo_hit;
  logic             mem_read;
  logic             mem_write;
  logic             adr_src;

  assign mem_ready = mem_bus.Mem_Ready_i;
  assign in_wait   = state_q inside {S_FETCH, S_MEM_READ, S_MEM_WRITE};
  assign tmo_hit   = (TIMEOUT_CYCLES > 0) && in_wait && !mem_ready && (tmo_cnt_q == TMO_LAST);

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    illegal_d = 1'b0;
    bus_err_d = tmo_hit;
    tmo_cnt_d = (in_wait && !mem_ready && !tmo_hit) ? tmo_cnt_q + CNT_W'(1) : '0;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        op_d = Op_i;
        case (Op_i)
          OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
          OP_R:              state_d = S_EXEC_R;
          OP_I:              state_d = S_EXEC_I;
          OP_LUI:            state_d = S_EXEC_LUI;
          OP_BEQ:            state_d = S_BRANCH;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: state_d = (op_q == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ: begin
        if (mem_ready)    state_d = S_MEM_WB;
        else if (tmo_hit) state_d = S_FETCH;
      end
      S_MEM_WRITE: begin
        if (mem_ready || tmo_hit) state_d = S_FETCH;
      end
      S_EXEC_R, S_EXEC_I, S_EXEC_LUI: state_d = S_ALU_WB;
      S_MEM_WB, S_ALU_WB, S_BRANCH:   state_d = S_FETCH;
      default:                        state_d = S_FETCH;
    endcase
  end

  // Moore decode of the current state; only the FETCH register enables look at ready.
  always_comb begin
    PC_Write_o   = 1'b0;
    IR_Write_o   = 1'b0;
    adr_src      = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    Reg_Write_o  = 1'b0;
    Branch_o     = 1'b0;
    ALU_Src_A_o  = 2'b00;
    ALU_Src_B_o  = 2'b00;
    Result_Src_o = 2'b00;
    ALU_Op_o     = 3'b000;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem_read     = 1'b1;
          PC_Write_o   = mem_ready;
          IR_Write_o   = mem_ready;
          ALU_Src_B_o  = 2'b10;
          Result_Src_o = 2'b10;
          ALU_Op_o     = 3'b010;
        end
        S_DECODE: begin
          ALU_Src_A_o = 2'b01;
          ALU_Src_B_o = 2'b01;
          ALU_Op_o    = 3'b010;
        end
        S_MEM_ADDR: begin
          ALU_Src_A_o = 2'b10;
          ALU_Src_B_o = 2'b01;
          ALU_Op_o    = 3'b010;
        end
        S_MEM_READ: begin
          mem_read = 1'b1;
          adr_src  = 1'b1;
        end
        S_MEM_WB: begin
          Reg_Write_o  = 1'b1;
          Result_Src_o = 2'b01;
        end
        S_MEM_WRITE: begin
          mem_write = 1'b1;
          adr_src   = 1'b1;
        end
        S_EXEC_R: begin
          ALU_Src_A_o = 2'b10;
          ALU_Src_B_o = 2'b00;
          ALU_Op_o    = 3'b000;
        end
        S_EXEC_I: begin
          ALU_Src_A_o = 2'b10;
          ALU_Src_B_o = 2'b01;
          ALU_Op_o    = 3'b001;
        end
        S_EXEC_LUI: begin
          ALU_Src_B_o = 2'b01;
          ALU_Op_o    = 3'b100;
        end
        S_ALU_WB: begin
          Reg_Write_o = 1'b1;
        end
        S_BRANCH: begin
          ALU_Src_A_o = 2'b10;
          ALU_Src_B_o = 2'b00;
          ALU_Op_o    = 3'b011;
          Branch_o    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign mem_bus.Mem_Read_o  = mem_read;
  assign mem_bus.Mem_Write_o = mem_write;
  assign mem_bus.Adr_Src_o   = adr_src;
  assign State_o             = state_q;
  assign Illegal_Op_o        = illegal_q;
  assign Bus_Error_o         = bus_err_q;

`ifdef MC_RETIRE_COUNT_EN
  logic [COUNT_W-1:0] retired_q, retired_d;
  logic               retire;

  // Illegal opcodes and timeouts reach FETCH by other paths and are deliberately not counted.
  assign retire = (state_q == S_MEM_WB) || (state_q == S_ALU_WB) || (state_q == S_BRANCH) ||
                  ((state_q == S_MEM_WRITE) && mem_ready);

  always_comb begin
    retired_d = retired_q;
    if (retire) retired_d = retired_q + COUNT_W'(1);
  end

  assign Retired_o = retired_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      tmo_cnt_q <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
`ifdef MC_RETIRE_COUNT_EN
      retired_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      tmo_cnt_q <= tmo_cnt_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
`ifdef MC_RETIRE_COUNT_EN
      retired_q <= retired_d;
`endif
    end
  end

endmodule

// File: doc/multi_cycle_control.md
Name: multi_cycle_control

Overview:
- Multi-cycle sequencer FSM for the RISC-V core. It replaces single-cycle decode for the multi-cycle datapath: one shared memory, IR/MDR/ALUOut registers, and a PC updated through the ALU.
- Each instruction is walked through fetch, decode, execute, memory and writeback states.
- Every memory access waits on a ready handshake, with a timeout.
- Sits between the instruction register opcode field and all datapath mux selects and write enables.

Parameters:
- TIMEOUT_CYCLES, 16: consecutive not-ready cycles in a wait state before bus error. 0 disables the timeout.
- COUNT_W, 32: width of the retired-instruction counter (optional feature only).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- Op_i  in  7  opcode from IR[6:0]; sampled only in DECODE.
- Mem_Ready_i  in  1  memory completes the current read or write this cycle.
- PC_Write_o  out  1  PC register enable.
- IR_Write_o  out  1  IR (and old-PC) register enable.
- Adr_Src_o  out  1  memory address select: 0 = PC, 1 = ALUOut.
- Mem_Read_o  out  1  memory read request.
- Mem_Write_o  out  1  memory write request.
- Reg_Write_o  out  1  register file write enable.
- Branch_o  out  1  PC load from ALUOut when ALU zero flag is set.
- ALU_Src_A_o  out  2  A operand: 00 = PC, 01 = old PC, 10 = rs1.
- ALU_Src_B_o  out  2  B operand: 00 = rs2, 01 = imm, 10 = const 4.
- Result_Src_o  out  2  writeback / PC source: 00 = ALUOut, 01 = MDR, 10 = ALU result.
- ALU_Op_o  out  3  000 = R, 001 = I-logic, 010 = add, 011 = sub, 100 = LUI.
- State_o  out  4  current state encoding.
- Illegal_Op_o  out  1  one-cycle pulse for an unknown opcode.
- Bus_Error_o  out  1  one-cycle pulse on memory timeout.

Behaviour:
- Clocking and reset:
  - Single clock.
  - Synchronous active-high reset sets state to FETCH, clears the timeout counter, and clears the Illegal_Op_o and Bus_Error_o pulse registers.
  - All other outputs are a combinational (Moore) decode of state, except the FETCH enables, which are gated by Mem_Ready_i.
  - During reset and in any undefined state, every enable is 0 and all selects are 00/000.
  - Reset mid-access drops the request on the next edge.
- State encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXEC_R 6, EXEC_I 7, EXEC_LUI 8, ALU_WB 9, BRANCH 10. Values 11-15 are undefined and go to FETCH.
- Opcodes decoded in DECODE: R 0110011, I-logic 0010011, load 0000011, store 0100011, LUI 0110111, BEQ 1100011.
- FETCH:
  - Outputs: Mem_Read=1, Adr_Src=0, A=00, B=10, ALU_Op=010, Result_Src=10.
  - PC_Write = IR_Write = Mem_Ready_i.
  - Transition: go to DECODE when Mem_Ready_i=1; otherwise stay.
- DECODE:
  - Outputs: A=01, B=01, ALU_Op=010 (branch target into ALUOut).
  - Transitions: load/store to MEM_ADDR; R to EXEC_R; I-logic to EXEC_I; LUI to EXEC_LUI; BEQ to BRANCH.
  - Any other opcode: go to FETCH and pulse Illegal_Op_o for 1 cycle. No register or memory write occurs.
- MEM_ADDR:
  - Outputs: A=10, B=01, ALU_Op=010.
  - Transition: Op_i captured in DECODE is held internally; load goes to MEM_READ, store goes to MEM_WRITE.
- MEM_READ:
  - Outputs: Mem_Read=1, Adr_Src=1.
  - Transition: go to MEM_WB on Mem_Ready_i.
- MEM_WB:
  - Outputs: Reg_Write=1, Result_Src=01.
  - Transition: go to FETCH.
- MEM_WRITE:
  - Outputs: Mem_Write=1, Adr_Src=1.
  - Transition: go to FETCH on Mem_Ready_i.
- EXEC_R: A=10, B=00, ALU_Op=000; go to ALU_WB.
- EXEC_I: A=10, B=01, ALU_Op=001; go to ALU_WB.
- EXEC_LUI: B=01, ALU_Op=100; go to ALU_WB.
- ALU_WB: Reg_Write=1, Result_Src=00; go to FETCH.
- BRANCH: A=10, B=00, ALU_Op=011, Branch=1, Result_Src=00; go to FETCH.
- Latency in cycles with zero wait states: R / I / LUI 4; load 5; store 4; BEQ 3. Each wait cycle adds 1.
- Timeout:
  - The counter clears on entry to FETCH, MEM_READ and MEM_WRITE, and increments each not-ready cycle spent in them.
  - When the count reaches TIMEOUT_CYCLES: pulse Bus_Error_o for 1 cycle, deassert the request, and go to FETCH. A FETCH timeout refetches the same PC, because PC_Write was never asserted.
  - If Mem_Ready_i is high in the same cycle the count reaches the limit, ready wins and no error is raised.

Optional Feature:
- Macro: MC_RETIRE_COUNT_EN.
- Defined:
  - Adds output Retired_o [COUNT_W-1:0], reset to 0.
  - Increments by 1 on each transition to FETCH from MEM_WB, ALU_WB, BRANCH, or from MEM_WRITE with Mem_Ready_i.
  - Does not increment on illegal opcode or bus error.
  - Wraps modulo 2^COUNT_W.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset high 2 cycles, then low, Mem_Ready_i=1, Op_i=0110011 -> State_o sequence 0,1,6,9,0. Reg_Write_o=1 only in state 9, with Result_Src_o=00.
- Op_i=0000011 with Mem_Ready_i low for 3 cycles in MEM_READ -> states 0,1,2,3,3,3,3,4,0. Mem_Read_o=1 and Adr_Src_o=1 throughout state 3. Reg_Write_o=1 in state 4 with Result_Src_o=01.
- Op_i=0100011, ready immediately -> Mem_Write_o=1 for exactly 1 cycle in state 5. Reg_Write_o never asserted. Retired_o increments by 1 (with MC_RETIRE_COUNT_EN defined).
- Op_i=1100011 -> states 0,1,10,0. In state 10: Branch_o=1, ALU_Op_o=011.
- Op_i=1111111 in DECODE -> Illegal_Op_o=1 for 1 cycle, next state 0, no write enables asserted, Retired_o unchanged.
- TIMEOUT_CYCLES=4, Mem_Ready_i held 0 in FETCH -> Bus_Error_o pulses after 4 wait cycles, PC_Write_o stays 0, FSM re-enters FETCH. Asserting reset in MEM_WRITE -> state 0 and Mem_Write_o=0 on the next edge.
